// File: rtl/demorgan_sweep_ctrl_if.sv
// Handshake bundle between a sweep start source / gate under test and demorgan_sweep_ctrl.
// The expected truth table travels as expect_tt because "expect" is a reserved word.
interface demorgan_sweep_ctrl_if #(
  parameter int ERR_W = 3
);
  logic             start;
  logic [3:0]       expect_tt;
  logic             c_in;
  logic             a_out;
  logic             b_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [3:0]       fail_vec;

  modport master (
    output start, expect_tt, c_in,
    input  a_out, b_out, busy, done, pass, err_count, fail_vec
  );

  modport slave (
    input  start, expect_tt, c_in,
    output a_out, b_out, busy, done, pass, err_count, fail_vec
  );
endinterface

// File: rtl/demorgan_sweep_ctrl.sv
// Sweeps a two-input gate through vectors 00,01,10,11, holding each HOLD_CYCLES cycles,
// and checks the gate output once per vector against a latched truth table.
module demorgan_sweep_ctrl #(
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_W       = 3
) (
  input logic                 clk,
  input logic                 rst,
  demorgan_sweep_ctrl_if.slave sw
);
  localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_DONE} state_t;

  state_t           state;
  logic [1:0]       idx;
  logic [HW-1:0]    hold;
  logic [3:0]       exp_q;
  logic             a_q;
  logic             b_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_q;
  logic [3:0]       fail_q;
  logic             mismatch;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Only meaningful on the last hold cycle of a vector; other cycles let the gate settle.
  assign mismatch = (sw.c_in != exp_q[idx]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      idx    <= '0;
      hold   <= '0;
      exp_q  <= '0;
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      err_q  <= '0;
      fail_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          a_q    <= 1'b0;
          b_q    <= 1'b0;
          if (sw.start) begin
            exp_q  <= sw.expect_tt;
            err_q  <= '0;
            fail_q <= '0;
            pass_q <= 1'b0;
            idx    <= '0;
            hold   <= '0;
            busy_q <= 1'b1;
            state  <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          if (hold == HOLD_LAST) begin
            hold <= '0;
            if (mismatch) begin
              fail_q[idx] <= 1'b1;
              err_q       <= sat_inc(err_q);
            end
            if (idx == 2'd3) begin
              // Verdict folds in the final sample so pass is valid in the DONE cycle.
              state  <= S_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              a_q    <= 1'b0;
              b_q    <= 1'b0;
              pass_q <= ~mismatch && (fail_q == 4'b0000);
            end else begin
              idx        <= idx + 2'd1;
              {a_q, b_q} <= idx + 2'd1;
            end
          end else begin
            hold <= hold + 1'b1;
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign sw.a_out     = a_q;
  assign sw.b_out     = b_q;
  assign sw.busy      = busy_q;
  assign sw.done      = done_q;
  assign sw.pass      = pass_q;
  assign sw.err_count = err_q;
  assign sw.fail_vec  = fail_q;
endmodule

// File: tb/tb_demorgan_sweep_ctrl.sv
// Bench for demorgan_sweep_ctrl: table and random sweeps on an H=4 instance,
// restart/reset corner cases, and back-to-back sweeps on an H=2 instance.
module tb_demorgan_sweep_ctrl;
  localparam int H4    = 4;
  localparam int H2    = 2;
  localparam int ERR_W = 3;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demorgan_sweep_ctrl_if #(.ERR_W(ERR_W)) sw4 ();
  demorgan_sweep_ctrl_if #(.ERR_W(ERR_W)) sw2 ();

  demorgan_sweep_ctrl #(.HOLD_CYCLES(H4), .ERR_W(ERR_W)) dut4 (
    .clk(clk), .rst(rst), .sw(sw4.slave)
  );
  demorgan_sweep_ctrl #(.HOLD_CYCLES(H2), .ERR_W(ERR_W)) dut2 (
    .clk(clk), .rst(rst), .sw(sw2.slave)
  );

  // NAND gate under test for the H=2 instance
  assign sw2.c_in = ~(sw2.a_out & sw2.b_out);

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] exp_tt;
    logic [3:0] gate;
    int         glitch;
    logic [3:0] fail;
    int         err;
    logic       pass;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic int ref_err(input logic [3:0] fail);
    int n;
    n = $countones(fail);
    return (n > ERR_MAX) ? ERR_MAX : n;
  endfunction

  // One sweep on the H=4 instance. gate is the truth table of the gate under test;
  // glitch 1 inverts c_in off the sample cycles, glitch 2 randomises it there.
  task automatic run_sweep(input logic [3:0] exp_tt, input logic [3:0] gate, input int glitch,
                           input bit restart_mid, input logic [3:0] req_fail, input int req_err,
                           input logic req_pass, input string tag);
    @(negedge clk);
    sw4.start     = 1'b1;
    sw4.expect_tt = exp_tt;
    @(posedge clk);
    for (int k = 1; k <= 4 * H4 + 1; k++) begin
      bit   smp;
      logic g;
      @(negedge clk);
      if (k == 1) sw4.start = 1'b0;
      if (k <= 4 * H4) begin
        chk($sformatf("%s busy k=%0d", tag, k), sw4.busy, 1'b1);
        chk($sformatf("%s done k=%0d", tag, k), sw4.done, 1'b0);
        chk($sformatf("%s ab k=%0d", tag, k), {sw4.a_out, sw4.b_out}, (k - 1) / H4);
      end else begin
        chk($sformatf("%s done_end", tag), sw4.done, 1'b1);
        chk($sformatf("%s busy_end", tag), sw4.busy, 1'b0);
        chk($sformatf("%s ab_end", tag), {sw4.a_out, sw4.b_out}, 2'b00);
        chk($sformatf("%s pass", tag), sw4.pass, req_pass);
        chk($sformatf("%s err_count", tag), sw4.err_count, req_err);
        chk($sformatf("%s fail_vec", tag), sw4.fail_vec, req_fail);
      end
      if (restart_mid && k == 5) begin
        sw4.start     = 1'b1;
        sw4.expect_tt = ~exp_tt;
      end
      if (restart_mid && k == 7) sw4.start = 1'b0;
      smp = (k % H4 == 0);
      g   = gate[{sw4.a_out, sw4.b_out}];
      if (!smp && glitch == 1) g = ~g;
      else if (!smp && glitch == 2) g = 1'($urandom_range(0, 1));
      sw4.c_in = g;
    end
    @(negedge clk);
    chk($sformatf("%s done_after", tag), sw4.done, 1'b0);
    chk($sformatf("%s pass_held", tag), sw4.pass, req_pass);
    chk($sformatf("%s err_held", tag), sw4.err_count, req_err);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[5];
    tbl[0] = '{4'b0111, 4'b0111, 0, 4'b0000, 0, 1'b1};  // NAND matches
    tbl[1] = '{4'b0111, 4'b0000, 0, 4'b0111, 3, 1'b0};  // c_in stuck at 0
    tbl[2] = '{4'b1000, 4'b0111, 0, 4'b1111, 4, 1'b0};  // AND table vs NAND gate
    tbl[3] = '{4'b0110, 4'b1110, 0, 4'b1000, 1, 1'b0};  // XOR table vs OR gate
    tbl[4] = '{4'b0111, 4'b0111, 1, 4'b0000, 0, 1'b1};  // glitches off sample cycles

    sw4.start = 1'b0; sw4.expect_tt = 4'b0000; sw4.c_in = 1'b0;
    sw2.start = 1'b0; sw2.expect_tt = 4'b0000;
    repeat (2) @(negedge clk);
    chk("rst busy", sw4.busy, 1'b0);
    chk("rst done", sw4.done, 1'b0);
    chk("rst pass", sw4.pass, 1'b0);
    chk("rst ab", {sw4.a_out, sw4.b_out}, 2'b00);
    chk("rst err", sw4.err_count, 0);
    chk("rst fail", sw4.fail_vec, 4'b0000);
    chk("rst busy2", sw2.busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle busy", sw4.busy, 1'b0);

    for (int i = 0; i < 5; i++)
      run_sweep(tbl[i].exp_tt, tbl[i].gate, tbl[i].glitch, 1'b0,
                tbl[i].fail, tbl[i].err, tbl[i].pass, $sformatf("tbl%0d", i));

    for (int i = 0; i < 6; i++) begin
      logic [3:0] e, g;
      e = 4'($urandom);
      g = 4'($urandom);
      run_sweep(e, g, 2, 1'b0, e ^ g, ref_err(e ^ g), (e == g), $sformatf("rnd%0d", i));
    end

    run_sweep(4'b0111, 4'b0111, 0, 1'b1, 4'b0000, 0, 1'b1, "restart_mid");

    // Reset during vector 10 with errors already recorded
    @(negedge clk);
    sw4.start = 1'b1; sw4.expect_tt = 4'b0111; sw4.c_in = 1'b0;
    @(posedge clk);
    @(negedge clk);
    sw4.start = 1'b0;
    repeat (2 * H4 + 1) @(negedge clk);
    chk("pre_rst a_out", sw4.a_out, 1'b1);
    chk("pre_rst err", sw4.err_count, 2);
    rst = 1'b1;
    #1;
    chk("async_rst busy", sw4.busy, 1'b0);
    chk("async_rst a_out", sw4.a_out, 1'b0);
    chk("async_rst b_out", sw4.b_out, 1'b0);
    chk("async_rst err", sw4.err_count, 0);
    chk("async_rst fail", sw4.fail_vec, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst idle", sw4.busy, 1'b0);
    run_sweep(4'b0111, 4'b0111, 0, 1'b0, 4'b0000, 0, 1'b1, "after_rst");

    // Back-to-back on H=2: period 4H+2 = 10 cycles
    @(negedge clk);
    sw2.expect_tt = 4'b0111;
    sw2.start     = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      int p;
      @(negedge clk);
      p = (k - 1) % (4 * H2 + 2);
      chk($sformatf("b2b busy k=%0d", k), sw2.busy, (p < 4 * H2));
      chk($sformatf("b2b done k=%0d", k), sw2.done, (p == 4 * H2));
      if (p == 4 * H2) begin
        chk($sformatf("b2b pass k=%0d", k), sw2.pass, 1'b1);
        chk($sformatf("b2b fail_vec k=%0d", k), sw2.fail_vec, 4'b0000);
      end
    end
    sw2.start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
